// File: rtl/axis_rr_mux.sv
// Round-robin AXI-Stream multiplexer: N input lanes onto one registered output,
// with each grant held for a whole packet (until the beat carrying tlast).
module axis_rr_mux #(
    parameter int NUM_RX_LANES = 4,
    parameter int DATA_WIDTH   = 32,
    localparam int KEEP_WIDTH  = DATA_WIDTH / 8,
    localparam int LANE_W      = $clog2(NUM_RX_LANES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_RX_LANES-1:0]            rx_axis_tvalid,
    input  logic [NUM_RX_LANES*DATA_WIDTH-1:0] rx_axis_tdata,
    input  logic [NUM_RX_LANES*KEEP_WIDTH-1:0] rx_axis_tkeep,
    input  logic [NUM_RX_LANES-1:0]            rx_axis_tlast,
    output logic [NUM_RX_LANES-1:0]            rx_axis_tready,
    input  logic [NUM_RX_LANES-1:0]            lane_enable,
    input  logic                               tx_axis_tready,
    output logic                               tx_axis_tvalid,
    output logic [DATA_WIDTH-1:0]              tx_axis_tdata,
    output logic [KEEP_WIDTH-1:0]              tx_axis_tkeep,
    output logic                               tx_axis_tlast,
    output logic [LANE_W-1:0]                  tx_axis_tdest,
    output logic                               busy,
    output logic [15:0]                        tx_pkt_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [LANE_W:0]   LANES_EXT = (LANE_W+1)'(NUM_RX_LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_RX_LANES - 1);

    state_t                  state_q, state_d;
    logic [LANE_W-1:0]       rr_ptr_q, grant_q, arb_idx, next_ptr;
    logic [NUM_RX_LANES-1:0] cand;
    logic [LANE_W:0]         scan;
    logic                    arb_found;
    logic                    sel_valid, sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;
    logic                    out_ready, accept;

    assign cand = rx_axis_tvalid & lane_enable;

    // Scan from rr_ptr upward, wrapping at the last real lane, so indices
    // >= NUM_RX_LANES are never produced.
    always_comb begin : arbiter
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        arb_found = 1'b0;
        arb_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_RX_LANES; k++) begin
            // NOTE: blocking assignments here model ordered combinational evaluation.
            scan = {1'b0, rr_ptr_q} + (LANE_W+1)'(k);
            if (scan >= LANES_EXT) scan = scan - LANES_EXT;
            if (!arb_found && cand[scan[LANE_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = scan[LANE_W-1:0];
            end
        end
    end

    always_comb begin : lane_select
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int k = 0; k < NUM_RX_LANES; k++) begin
            if (grant_q == LANE_W'(k)) begin
                sel_valid = rx_axis_tvalid[k];
                sel_last  = rx_axis_tlast[k];
                sel_data  = rx_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = rx_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    assign out_ready = !tx_axis_tvalid || tx_axis_tready;
    assign accept    = (state_q == LOCKED) && sel_valid && out_ready;
    assign next_ptr  = (grant_q == LAST_LANE) ? '0 : grant_q + 1'b1;
    assign busy      = (state_q == LOCKED);

    // Only the granted lane sees backpressure relief; lane_enable is not
    // consulted here so a packet in flight always completes.
    always_comb begin : ready_gen
        rx_axis_tready = '0;
        for (int k = 0; k < NUM_RX_LANES; k++) begin
            if (state_q == LOCKED && grant_q == LANE_W'(k)) rx_axis_tready[k] = out_ready;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_found) state_d = LOCKED;
            LOCKED:  if (accept && sel_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            if (state_q == IDLE && arb_found) grant_q <= arb_idx;
            if (accept && sel_last) rr_ptr_q <= next_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_axis_tvalid <= 1'b0;
            tx_axis_tdata  <= '0;
            tx_axis_tkeep  <= '0;
            tx_axis_tlast  <= 1'b0;
            tx_axis_tdest  <= '0;
        end else if (accept) begin
            tx_axis_tvalid <= 1'b1;
            tx_axis_tdata  <= sel_data;
            tx_axis_tkeep  <= sel_keep;
            tx_axis_tlast  <= sel_last;
            tx_axis_tdest  <= grant_q;
        end else if (out_ready) begin
            tx_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pkt_count <= '0;
        end else if (tx_axis_tvalid && tx_axis_tready && tx_axis_tlast) begin
            tx_pkt_count <= tx_pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_rr_mux.sv
// Directed bench for axis_rr_mux: per-lane beat sources, an output beat log,
// and hand-computed expectations for arbitration order, stalls, masking and reset.
module tb_axis_rr_mux;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int LW   = 2;
    localparam int MAXB = 32;
    localparam int LOGN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    rx_axis_tvalid;
    logic [N*DW-1:0] rx_axis_tdata;
    logic [N*KW-1:0] rx_axis_tkeep;
    logic [N-1:0]    rx_axis_tlast;
    logic [N-1:0]    rx_axis_tready;
    logic [N-1:0]    lane_enable;
    logic            tx_axis_tready;
    logic            tx_axis_tvalid;
    logic [DW-1:0]   tx_axis_tdata;
    logic [KW-1:0]   tx_axis_tkeep;
    logic            tx_axis_tlast;
    logic [LW-1:0]   tx_axis_tdest;
    logic            busy;
    logic [15:0]     tx_pkt_count;

    always #5 clk = ~clk;

    axis_rr_mux #(.NUM_RX_LANES(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tdata(rx_axis_tdata),
        .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tlast(rx_axis_tlast),
        .rx_axis_tready(rx_axis_tready), .lane_enable(lane_enable),
        .tx_axis_tready(tx_axis_tready), .tx_axis_tvalid(tx_axis_tvalid),
        .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
        .tx_axis_tlast(tx_axis_tlast), .tx_axis_tdest(tx_axis_tdest),
        .busy(busy), .tx_pkt_count(tx_pkt_count)
    );

    logic [DW-1:0] src_data [N][MAXB];
    logic          src_last [N][MAXB];
    int            src_head [N];
    int            src_tail [N];
    logic [DW-1:0] out_data [LOGN];
    logic [LW-1:0] out_dest [LOGN];
    logic          out_last [LOGN];
    int            out_cyc  [LOGN];
    int            out_n;
    int            cyc;
    int            hs_count;
    int            n_checks;
    int            n_pass;
    bit            free_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push(input int lane, input logic [31:0] d, input logic last);
        src_data[lane][src_tail[lane]] = d;
        src_last[lane][src_tail[lane]] = last;
        src_tail[lane]++;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        out_n = 0;
    endtask

    task automatic drive_inputs();
        rx_axis_tkeep = '1;
        for (int i = 0; i < N; i++) begin
            if (free_run && i == 0) begin
                rx_axis_tvalid[i]          = 1'b1;
                rx_axis_tdata[i*DW +: DW]  = 32'hCAFE_0000;
                rx_axis_tlast[i]           = 1'b1;
            end else if (src_head[i] < src_tail[i]) begin
                rx_axis_tvalid[i]          = 1'b1;
                rx_axis_tdata[i*DW +: DW]  = src_data[i][src_head[i]];
                rx_axis_tlast[i]           = src_last[i][src_head[i]];
            end else begin
                rx_axis_tvalid[i]          = 1'b0;
                rx_axis_tdata[i*DW +: DW]  = '0;
                rx_axis_tlast[i]           = 1'b0;
            end
        end
    endtask

    // One clock: note handshakes before the edge, then advance the sources.
    task automatic tick();
        logic [N-1:0] acc;
        #1;
        acc = rx_axis_tvalid & rx_axis_tready;
        if (tx_axis_tvalid && tx_axis_tready) begin
            hs_count++;
            if (!free_run && out_n < LOGN) begin
                out_data[out_n] = tx_axis_tdata;
                out_dest[out_n] = tx_axis_tdest;
                out_last[out_n] = tx_axis_tlast;
                out_cyc[out_n]  = cyc;
                out_n++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (acc[i] && src_head[i] < src_tail[i]) src_head[i]++;
        drive_inputs();
        #1;
    endtask

    task automatic run_until(input int n, input int bound, input string tag);
        int c;
        c = 0;
        while (out_n < n && c < bound) begin
            tick();
            c++;
        end
        check(tag, 32'(out_n), 32'(n));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, 32'(tx_axis_tvalid), 32'd0);
        check({tag, "_tdata"},  tx_axis_tdata,       32'd0);
        check({tag, "_tkeep"},  32'(tx_axis_tkeep),  32'd0);
        check({tag, "_tlast"},  32'(tx_axis_tlast),  32'd0);
        check({tag, "_tdest"},  32'(tx_axis_tdest),  32'd0);
        check({tag, "_busy"},   32'(busy),           32'd0);
        check({tag, "_rready"}, 32'(rx_axis_tready), 32'd0);
        check({tag, "_count"},  32'(tx_pkt_count),   32'd0);
    endtask

    initial begin
        int guard;
        n_checks = 0; n_pass = 0; cyc = 0; hs_count = 0; free_run = 1'b0;
        lane_enable = 4'hF;
        tx_axis_tready = 1'b1;
        do_reset();
        check_all_zero("reset");

        // Single lane: lane 2 sends A0..A3.
        for (int b = 0; b < 4; b++) push(2, 32'hA0 + 32'(b), b == 3);
        drive_inputs();
        #1;
        check("idle_no_ready", 32'(rx_axis_tready), 32'd0);
        tick();
        check("lock_busy", 32'(busy), 32'd1);
        check("lock_ready", 32'(rx_axis_tready), 32'b0100);
        tick();
        check("lat_valid", 32'(tx_axis_tvalid), 32'd1);
        check("lat_data", tx_axis_tdata, 32'hA0);
        check("lat_dest", 32'(tx_axis_tdest), 32'd2);
        run_until(4, 20, "single_beats");
        for (int b = 0; b < 4; b++) begin
            check("single_data", out_data[b], 32'hA0 + 32'(b));
            check("single_dest", 32'(out_dest[b]), 32'd2);
            check("single_last", 32'(out_last[b]), 32'(b == 3));
        end
        check("single_count", 32'(tx_pkt_count), 32'd1);
        check("single_idle", 32'(busy), 32'd0);
        check("single_vclr", 32'(tx_axis_tvalid), 32'd0);

        // Reset during beat 2 of 4 on lane 3 (rr_ptr is 3 here).
        out_n = 0;
        for (int b = 0; b < 4; b++) push(3, 32'hD0 + 32'(b), b == 3);
        drive_inputs();
        tick();
        tick();
        tick();
        check("mid_beat2", tx_axis_tdata, 32'hD1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        do_reset();
        push(0, 32'hE0, 1'b1);
        push(3, 32'hF0, 1'b1);
        drive_inputs();
        tick();
        check("fresh_grant", 32'(rx_axis_tready), 32'b0001);
        run_until(2, 20, "fresh_beats");
        check("fresh_dest0", 32'(out_dest[0]), 32'd0);
        check("fresh_data0", out_data[0], 32'hE0);
        check("fresh_dest1", 32'(out_dest[1]), 32'd3);

        // Round robin: every lane holds two 2-beat packets.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < N; l++)
                for (int b = 0; b < 2; b++) push(l, 32'(l * 256 + p * 16 + b), b == 1);
        drive_inputs();
        run_until(16, 100, "rr_beats");
        for (int q = 0; q < 8; q++) begin
            for (int b = 0; b < 2; b++) begin
                check("rr_dest", 32'(out_dest[2*q+b]), 32'(q % 4));
                check("rr_data", out_data[2*q+b], 32'((q % 4) * 256 + (q / 4) * 16 + b));
            end
            check("rr_contig", 32'(out_cyc[2*q+1] - out_cyc[2*q]), 32'd1);
            if (q > 0) check("rr_gap", 32'(out_cyc[2*q] - out_cyc[2*q-1]), 32'd2);
        end

        // Backpressure: 3-cycle stall while B1 is on the output.
        do_reset();
        for (int b = 0; b < 4; b++) push(1, 32'hB0 + 32'(b), b == 3);
        drive_inputs();
        tick();
        tick();
        tick();
        tx_axis_tready = 1'b0;
        #1;
        check("stall_rready", 32'(rx_axis_tready), 32'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_valid", 32'(tx_axis_tvalid), 32'd1);
            check("stall_data", tx_axis_tdata, 32'hB1);
            check("stall_keep", 32'(tx_axis_tkeep), 32'hF);
            check("stall_dest", 32'(tx_axis_tdest), 32'd1);
            check("stall_last", 32'(tx_axis_tlast), 32'd0);
            check("stall_rready", 32'(rx_axis_tready), 32'd0);
        end
        tx_axis_tready = 1'b1;
        run_until(4, 20, "bp_beats");
        repeat (3) tick();
        check("bp_no_dup", 32'(out_n), 32'd4);
        for (int b = 0; b < 4; b++) check("bp_data", out_data[b], 32'hB0 + 32'(b));

        // Masking: only lanes 1 and 3 enabled.
        do_reset();
        lane_enable = 4'b1010;
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < N; l++)
                for (int b = 0; b < 2; b++) push(l, 32'(l * 256 + p * 16 + b), b == 1);
        drive_inputs();
        run_until(8, 60, "mask_beats");
        for (int q = 0; q < 4; q++) begin
            check("mask_dest", 32'(out_dest[2*q]), (q % 2 == 0) ? 32'd1 : 32'd3);
            check("mask_data", out_data[2*q], (q % 2 == 0) ? 32'(256 + (q / 2) * 16) : 32'(768 + (q / 2) * 16));
        end
        out_n = 0;
        push(1, 32'hC0, 1'b0);
        push(1, 32'hC1, 1'b0);
        push(1, 32'hC2, 1'b1);
        push(3, 32'h60, 1'b1);
        drive_inputs();
        tick();
        tick();
        check("mask_c0", tx_axis_tdata, 32'hC0);
        lane_enable = 4'b1000;
        run_until(4, 30, "mask_hold");
        for (int b = 0; b < 3; b++) begin
            check("mask_hold_data", out_data[b], 32'hC0 + 32'(b));
            check("mask_hold_dest", 32'(out_dest[b]), 32'd1);
        end
        check("mask_next_dest", 32'(out_dest[3]), 32'd3);
        lane_enable = 4'hF;

        // Wrap: rr_ptr reaches 3, then only lane 0 is valid.
        do_reset();
        push(2, 32'h11, 1'b1);
        drive_inputs();
        run_until(1, 10, "wrap_pre");
        push(0, 32'h22, 1'b1);
        drive_inputs();
        run_until(2, 10, "wrap_beats");
        check("wrap_dest", 32'(out_dest[1]), 32'd0);
        check("wrap_data", out_data[1], 32'h22);

        // Packet counter wrap after 65536 single-beat packets.
        do_reset();
        free_run = 1'b1;
        hs_count = 0;
        drive_inputs();
        guard = 0;
        while (hs_count < 65535 && guard < 140000) begin
            tick();
            guard++;
        end
        check("count_ffff", 32'(tx_pkt_count), 32'hFFFF);
        while (hs_count < 65536 && guard < 140000) begin
            tick();
            guard++;
        end
        check("count_wrap", 32'(tx_pkt_count), 32'd0);
        free_run = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
